// File: rtl/axis_level_trigger.sv
`default_nettype none
// ============================================================================
// Module   : axis_level_trigger
// Purpose  : Level/edge trigger on a signed AXI-Stream. After an arm request
//            the block waits for the signal to cross (level -/+ hysteresis),
//            then for it to reach the level, and then forwards a fixed number
//            of samples to the downstream snapshot stage through a one-deep
//            registered output.
// Ports    : aclk, aresetn      - clock, synchronous active-low reset
//            arm                - one-cycle request to start a search
//            cfg_level/hyst/edge/count - configuration, latched on arm
//            s_axis_*           - sample input stream
//            m_axis_*           - passed-sample output stream
//            trig_out           - one-cycle pulse when the trigger fires
//            sts_state          - current state encoding
// Revision : 1.0 - initial release
// ============================================================================
module axis_level_trigger #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        arm,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_level,
    input  logic [AXIS_TDATA_WIDTH-1:0] cfg_hyst,
    input  logic                        cfg_edge,
    input  logic [CNTR_WIDTH-1:0]       cfg_count,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        trig_out,
    output logic [2:0]                  sts_state
);

    // Thresholds are level +/- an unsigned hysteresis of full data width.
    // Their range spans roughly three times the signed sample range, so two
    // guard bits are carried to keep every threshold and compare exact.
    localparam int c_CMP_WIDTH = AXIS_TDATA_WIDTH + 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_PRIMED = 3'd2,
        ST_PASS   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                      r_state;
    logic [AXIS_TDATA_WIDTH-1:0] r_level;
    logic [AXIS_TDATA_WIDTH-1:0] r_hyst;
    logic                        r_edge;
    logic [CNTR_WIDTH-1:0]       r_count;
    logic [CNTR_WIDTH-1:0]       r_cnt;
    logic [AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                        r_tvalid;
    logic                        r_trig;

    logic signed [c_CMP_WIDTH-1:0] w_sample;
    logic signed [c_CMP_WIDTH-1:0] w_level;
    logic signed [c_CMP_WIDTH-1:0] w_hyst;
    logic signed [c_CMP_WIDTH-1:0] w_lo_thr;
    logic signed [c_CMP_WIDTH-1:0] w_hi_thr;
    logic                          w_prime;
    logic                          w_fire;
    logic [CNTR_WIDTH-1:0]         w_count_eff;
    logic                          w_last;
    logic                          w_drain_ok;
    logic                          w_accept;
    logic                          w_rearm;

    assign w_sample = {{2{s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};
    assign w_level  = {{2{r_level[AXIS_TDATA_WIDTH-1]}}, r_level};
    assign w_hyst   = {2'b00, r_hyst};
    assign w_lo_thr = w_level - w_hyst;
    assign w_hi_thr = w_level + w_hyst;

    // Rising: prime below (level - hyst), fire at/above level.
    // Falling: prime above (level + hyst), fire at/below level.
    assign w_prime = r_edge ? (w_sample > w_hi_thr) : (w_sample < w_lo_thr);
    assign w_fire  = r_edge ? (w_sample <= w_level) : (w_sample >= w_level);

    // A zero count still forwards the trigger sample itself.
    assign w_count_eff = (r_count == '0) ? CNTR_WIDTH'(1) : r_count;
    assign w_last      = ((r_cnt + CNTR_WIDTH'(1)) == w_count_eff);

    // Output register is free this cycle (empty, or being consumed now).
    assign w_drain_ok = ~r_tvalid | m_axis_tready;

    // Only PASS applies backpressure; everywhere else samples are discarded.
    assign s_axis_tready = ~aresetn | (r_state != ST_PASS) | w_drain_ok;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    // A re-arm from DONE waits until the last passed sample has been taken,
    // so that nothing pending leaks into ARMED and nothing is lost.
    assign w_rearm = arm & ((r_state == ST_IDLE) |
                            ((r_state == ST_DONE) & w_drain_ok));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state  <= ST_IDLE;
            r_level  <= '0;
            r_hyst   <= '0;
            r_edge   <= 1'b0;
            r_count  <= '0;
            r_cnt    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_trig   <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            // Consumption of the held sample; a new load below overrides it.
            if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end

            if (w_rearm) begin
                r_level <= cfg_level;
                r_hyst  <= cfg_hyst;
                r_edge  <= cfg_edge;
                r_count <= cfg_count;
                r_cnt   <= '0;
                r_state <= ST_ARMED;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_ARMED: begin
                        // A sample past both thresholds only primes here.
                        if (w_accept && w_prime) begin
                            r_state <= ST_PRIMED;
                        end
                    end
                    ST_PRIMED: begin
                        if (w_accept && w_fire) begin
                            r_tdata  <= s_axis_tdata;
                            r_tvalid <= 1'b1;
                            r_trig   <= 1'b1;
                            r_cnt    <= CNTR_WIDTH'(1);
                            r_state  <= (w_count_eff == CNTR_WIDTH'(1)) ?
                                        ST_DONE : ST_PASS;
                        end
                    end
                    ST_PASS: begin
                        if (w_accept) begin
                            r_tdata  <= s_axis_tdata;
                            r_tvalid <= 1'b1;
                            r_cnt    <= r_cnt + CNTR_WIDTH'(1);
                            if (w_last) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_DONE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign trig_out      = r_trig;
    assign sts_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_axis_level_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_level_trigger
// Purpose  : Directed self-checking bench for axis_level_trigger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_level_trigger;

    logic        aclk;
    logic        aresetn;
    logic        arm;
    logic [31:0] cfg_level;
    logic [31:0] cfg_hyst;
    logic        cfg_edge;
    logic [15:0] cfg_count;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        trig_out;
    logic [2:0]  sts_state;

    int n_checks = 0;
    int n_errors = 0;

    axis_level_trigger #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH      (16)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .arm          (arm),
        .cfg_level    (cfg_level),
        .cfg_hyst     (cfg_hyst),
        .cfg_edge     (cfg_edge),
        .cfg_count    (cfg_count),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .trig_out     (trig_out),
        .sts_state    (sts_state)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        cyc();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic do_arm(input logic [31:0] lvl, input logic [31:0] hy,
                          input logic ed, input logic [15:0] cnt);
        cfg_level = lvl;
        cfg_hyst  = hy;
        cfg_edge  = ed;
        cfg_count = cnt;
        arm       = 1'b1;
        cyc();
        arm       = 1'b0;
    endtask

    // Backpressure table: m_axis_tready, input sample, expected out data/state.
    logic [0:0]  bp_rdy [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] bp_din [8] = '{32'd20, 32'd20, 32'd30, 32'd30, 32'd40, 32'd40, 32'd50, 32'd50};
    logic [31:0] bp_dout[8] = '{32'd10, 32'd20, 32'd20, 32'd30, 32'd30, 32'd40, 32'd40, 32'd40};
    logic [0:0]  bp_vld [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  bp_st  [8] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};

    initial begin
        aresetn       = 1'b0;
        arm           = 1'b0;
        cfg_level     = '0;
        cfg_hyst      = '0;
        cfg_edge      = 1'b0;
        cfg_count     = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state
        cyc();
        cyc();
        chk("rst_state",  sts_state,     3'd0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata",  m_axis_tdata,  32'd0);
        chk("rst_trig",   trig_out,      1'b0);
        chk("rst_tready", s_axis_tready, 1'b1);
        aresetn = 1'b1;
        cyc();
        chk("idle_state", sts_state, 3'd0);

        // Rising trigger: level 100, hyst 10, count 3
        do_arm(32'd100, 32'd10, 1'b0, 16'd3);
        chk("r_armed", sts_state, 3'd1);
        send(32'd50);
        chk("r_primed", sts_state, 3'd2);
        chk("r_primed_vld", m_axis_tvalid, 1'b0);
        send(32'd95);
        chk("r_95_state", sts_state, 3'd2);
        chk("r_95_trig", trig_out, 1'b0);
        send(32'd120);
        chk("r_fire_state", sts_state, 3'd3);
        chk("r_fire_trig", trig_out, 1'b1);
        chk("r_fire_vld", m_axis_tvalid, 1'b1);
        chk("r_fire_data", m_axis_tdata, 32'd120);
        send(32'd130);
        chk("r_130_trig", trig_out, 1'b0);
        chk("r_130_data", m_axis_tdata, 32'd130);
        send(32'd140);
        chk("r_140_data", m_axis_tdata, 32'd140);
        chk("r_140_state", sts_state, 3'd4);
        send(32'd150);
        chk("r_done_vld", m_axis_tvalid, 1'b0);
        chk("r_done_state", sts_state, 3'd4);
        chk("r_done_trig", trig_out, 1'b0);

        // Falling trigger: level -200, hyst 0, count 1 (re-arm from DONE)
        do_arm(-32'sd200, 32'd0, 1'b1, 16'd1);
        chk("f_armed", sts_state, 3'd1);
        send(32'd0);
        chk("f_primed", sts_state, 3'd2);
        send(-32'sd100);
        chk("f_m100_state", sts_state, 3'd2);
        send(-32'sd250);
        chk("f_fire_state", sts_state, 3'd4);
        chk("f_fire_data", m_axis_tdata, 32'hFFFF_FF06);
        chk("f_fire_vld", m_axis_tvalid, 1'b1);
        chk("f_fire_trig", trig_out, 1'b1);
        cyc();
        chk("f_after_vld", m_axis_tvalid, 1'b0);
        chk("f_after_trig", trig_out, 1'b0);

        // Backpressure: count 4, m_axis_tready toggling
        do_arm(32'd0, 32'd0, 1'b0, 16'd4);
        send(-32'sd5);
        chk("bp_primed", sts_state, 3'd2);
        send(32'd10);
        chk("bp_fire_data", m_axis_tdata, 32'd10);
        chk("bp_fire_state", sts_state, 3'd3);
        for (int i = 0; i < 8; i++) begin
            m_axis_tready = bp_rdy[i][0];
            s_axis_tdata  = bp_din[i];
            s_axis_tvalid = 1'b1;
            cyc();
            chk($sformatf("bp_vld_%0d", i),   m_axis_tvalid, bp_vld[i][0]);
            if (bp_vld[i][0]) begin
                chk($sformatf("bp_data_%0d", i), m_axis_tdata, bp_dout[i]);
            end
            chk($sformatf("bp_state_%0d", i), sts_state, bp_st[i]);
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;

        // Config isolation and arm filtering
        do_arm(32'd100, 32'd10, 1'b0, 16'd2);
        cfg_level = 32'd0;
        cfg_count = 16'd5;
        send(32'd50);
        chk("ci_primed", sts_state, 3'd2);
        arm = 1'b1;
        send(32'd60);
        arm = 1'b0;
        chk("ci_arm_ignored", sts_state, 3'd2);
        chk("ci_60_vld", m_axis_tvalid, 1'b0);
        send(32'd100);
        chk("ci_fire_state", sts_state, 3'd3);
        chk("ci_fire_data", m_axis_tdata, 32'd100);
        send(32'd110);
        chk("ci_done_state", sts_state, 3'd4);
        chk("ci_done_data", m_axis_tdata, 32'd110);
        // Re-arm in DONE with level 0, hyst 10, count 5
        cfg_hyst = 32'd10;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("ci_rearm", sts_state, 3'd1);
        chk("ci_rearm_vld", m_axis_tvalid, 1'b0);

        // Reset mid-PASS
        send(-32'sd20);
        chk("rp_primed", sts_state, 3'd2);
        send(32'd5);
        chk("rp_fire_state", sts_state, 3'd3);
        chk("rp_fire_vld", m_axis_tvalid, 1'b1);
        aresetn = 1'b0;
        cyc();
        chk("rp_rst_vld", m_axis_tvalid, 1'b0);
        chk("rp_rst_state", sts_state, 3'd0);
        chk("rp_rst_trig", trig_out, 1'b0);
        chk("rp_rst_tready", s_axis_tready, 1'b1);
        aresetn = 1'b1;
        send(32'd10);
        send(-32'sd30);
        send(32'd40);
        chk("rp_post_vld", m_axis_tvalid, 1'b0);
        chk("rp_post_trig", trig_out, 1'b0);
        chk("rp_post_state", sts_state, 3'd0);

        // count = 0 behaves as 1
        do_arm(32'd0, 32'd0, 1'b0, 16'd0);
        send(-32'sd1);
        send(32'd7);
        chk("c0_state", sts_state, 3'd4);
        chk("c0_data", m_axis_tdata, 32'd7);
        chk("c0_vld", m_axis_tvalid, 1'b1);
        send(32'd8);
        chk("c0_after_vld", m_axis_tvalid, 1'b0);
        chk("c0_after_state", sts_state, 3'd4);

        // Extreme level/hysteresis, rising: threshold is the minimum value
        do_arm(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 16'd1);
        send(32'h8000_0000);
        send(32'd0);
        send(32'h7FFF_FFFF);
        chk("ext_r_state", sts_state, 3'd1);
        chk("ext_r_vld", m_axis_tvalid, 1'b0);

        // Extreme level/hysteresis, falling: threshold beyond the maximum value
        aresetn = 1'b0;
        cyc();
        aresetn = 1'b1;
        do_arm(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 16'd1);
        send(32'h7FFF_FFFF);
        send(32'h8000_0000);
        send(32'd1);
        chk("ext_f_state", sts_state, 3'd1);
        chk("ext_f_trig", trig_out, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
